// File: rtl/gol_pkg.sv
// Shared definitions for the game-of-life datapath: grid geometry defaults,
// the grid type passed from the update logic to the scan driver, and a
// counter-width helper. No logic, no latency, no flow control.
package gol_pkg;

    localparam int unsigned GOL_ROWS = 16;
    localparam int unsigned GOL_COLS = 16;

    // Bit [r][c] set means the cell at row r, column c is alive.
    typedef logic [GOL_ROWS-1:0][GOL_COLS-1:0] grid_t;

    // Scan slot phase: outputs dark while settling, then the row is lit.
    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } scan_phase_e;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_scan_driver.sv
// LED matrix scan driver: snapshots the live grid each frame and lights it
//   one row at a time, with a dark blanking gap at the start of every row slot.
// Latency: all outputs registered; a grid change shows from the next frame start.
// Backpressure: none; free-running while enable=1, enable=0 blanks and rearms.
//
// Ports:
//   clock       rising-edge clock for all state
//   reset       asynchronous active-high reset, blanks the board immediately
//   enable      scan enable; low forces blank and restarts the frame
//   grid        live cell map, bit [r][c] = cell lit
//   row_drive   one-hot row select, active-high
//   col_drive   column data of the selected row, active-high
//   frame_done  one-cycle pulse in the first cycle of every frame
module led_scan_driver
    import gol_pkg::*;
#(
    parameter int unsigned ROWS         = GOL_ROWS,
    parameter int unsigned COLS         = GOL_COLS,
    parameter int unsigned BLANK_CYCLES = 64,
    parameter int unsigned DWELL_CYCLES = 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [ROWS-1:0][COLS-1:0]  grid,
    output logic [ROWS-1:0]            row_drive,
    output logic [COLS-1:0]            col_drive,
    output logic                       frame_done
);

    localparam int unsigned SLOT  = BLANK_CYCLES + DWELL_CYCLES;
    localparam int unsigned ROW_W = cnt_width(ROWS);
    localparam int unsigned CNT_W = cnt_width(SLOT);

    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [ROW_W-1:0]           row_q,        row_d;
    logic [CNT_W-1:0]           cnt_q,        cnt_d;
    logic [ROWS-1:0][COLS-1:0]  snap_q,       snap_d;
    // Set once the current frame has been started; cleared by reset and by
    // enable=0 so the next enabled edge is treated as a fresh frame start.
    logic                       run_q,        run_d;
    logic [ROWS-1:0]            row_drive_q,  row_drive_d;
    logic [COLS-1:0]            col_drive_q,  col_drive_d;
    logic                       frame_done_q, frame_done_d;

    scan_phase_e                phase_d;
    logic                       frame_start;

    // Next scan position and snapshot.
    always_comb begin
        row_d       = row_q;
        cnt_d       = cnt_q;
        snap_d      = snap_q;
        run_d       = run_q;
        frame_start = 1'b0;

        if (!enable) begin
            row_d = '0;
            cnt_d = '0;
            run_d = 1'b0;
        end else if (!run_q) begin
            // First enabled edge after reset or enable rise: restart at row 0.
            row_d       = '0;
            cnt_d       = '0;
            run_d       = 1'b1;
            frame_start = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (row_q == ROW_LAST) begin
                row_d       = '0;
                frame_start = 1'b1;
            end else begin
                row_d = row_q + ROW_W'(1);
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Taking the snapshot only at frame start keeps a frame tear-free.
        if (frame_start) begin
            snap_d = grid;
        end
    end

    // Phase and output decode of the next state, so the pins come straight
    // from flops and row/col switch together with the counter.
    always_comb begin
        phase_d      = (cnt_d < CNT_BLANK) ? PH_BLANK : PH_DRIVE;
        row_drive_d  = '0;
        col_drive_d  = '0;
        frame_done_d = frame_start;

        if (enable && (phase_d == PH_DRIVE)) begin
            row_drive_d[row_d] = 1'b1;
            col_drive_d        = snap_d[row_d];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_q        <= '0;
            cnt_q        <= '0;
            snap_q       <= '0;
            run_q        <= 1'b0;
            row_drive_q  <= '0;
            col_drive_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            row_q        <= row_d;
            cnt_q        <= cnt_d;
            snap_q       <= snap_d;
            run_q        <= run_d;
            row_drive_q  <= row_drive_d;
            col_drive_q  <= col_drive_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign row_drive  = row_drive_q;
    assign col_drive  = col_drive_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_scan_driver.sv
module tb_led_scan_driver;

    logic                clock;
    logic                reset;
    logic                enable;
    logic [3:0][3:0]     grid;
    logic [3:0]          row_drive;
    logic [3:0]          col_drive;
    logic                frame_done;

    logic                en_def;
    logic [15:0][15:0]   grid_def;
    logic [15:0]         row_def;
    logic [15:0]         col_def;
    logic                fd_def;

    int checks   = 0;
    int failures = 0;

    led_scan_driver #(
        .ROWS(4), .COLS(4), .BLANK_CYCLES(1), .DWELL_CYCLES(2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .grid       (grid),
        .row_drive  (row_drive),
        .col_drive  (col_drive),
        .frame_done (frame_done)
    );

    led_scan_driver dut_def (
        .clock      (clock),
        .reset      (reset),
        .enable     (en_def),
        .grid       (grid_def),
        .row_drive  (row_def),
        .col_drive  (col_def),
        .frame_done (fd_def)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected outputs for one cycle, plus the inputs to drive during it.
    typedef struct {
        logic [15:0] grid_nxt;
        logic        en_nxt;
        logic [3:0]  row;
        logic [3:0]  col;
        logic        fd;
    } vec_t;

    vec_t vec[28];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_vectors(input int last);
        for (int i = 0; i <= last; i++) begin
            tick();
            check($sformatf("row_drive c%0d", i), 32'(row_drive), 32'(vec[i].row));
            check($sformatf("col_drive c%0d", i), 32'(col_drive), 32'(vec[i].col));
            check($sformatf("frame_done c%0d", i), 32'(frame_done), 32'(vec[i].fd));
            grid   = vec[i].grid_nxt;
            enable = vec[i].en_nxt;
        end
    endtask

    task automatic restart(input logic [15:0] g);
        @(negedge clock);
        reset  = 1'b1;
        grid   = g;
        enable = 1'b1;
        @(negedge clock);
        reset  = 1'b0;
    endtask

    initial begin
        logic [3:0][3:0] mdl_snap;
        int lit[4];
        int last_fd;
        int idx;
        int n;
        int pop;
        bit seen;

        vec[0]  = '{16'h8421, 1'b1, 4'h0, 4'h0, 1'b1};
        vec[1]  = '{16'h8421, 1'b1, 4'h1, 4'h1, 1'b0};
        vec[2]  = '{16'h8421, 1'b1, 4'h1, 4'h1, 1'b0};
        vec[3]  = '{16'h8421, 1'b1, 4'h0, 4'h0, 1'b0};
        vec[4]  = '{16'h8421, 1'b1, 4'h2, 4'h2, 1'b0};
        vec[5]  = '{16'hFFFF, 1'b1, 4'h2, 4'h2, 1'b0};
        vec[6]  = '{16'hFFFF, 1'b1, 4'h0, 4'h0, 1'b0};
        vec[7]  = '{16'hFFFF, 1'b1, 4'h4, 4'h4, 1'b0};
        vec[8]  = '{16'hFFFF, 1'b1, 4'h4, 4'h4, 1'b0};
        vec[9]  = '{16'hFFFF, 1'b1, 4'h0, 4'h0, 1'b0};
        vec[10] = '{16'hFFFF, 1'b1, 4'h8, 4'h8, 1'b0};
        vec[11] = '{16'hFFFF, 1'b1, 4'h8, 4'h8, 1'b0};
        vec[12] = '{16'hFFFF, 1'b1, 4'h0, 4'h0, 1'b1};
        vec[13] = '{16'hFFFF, 1'b1, 4'h1, 4'hF, 1'b0};
        vec[14] = '{16'hFFFF, 1'b1, 4'h1, 4'hF, 1'b0};
        vec[15] = '{16'hFFFF, 1'b1, 4'h0, 4'h0, 1'b0};
        vec[16] = '{16'hFFFF, 1'b1, 4'h2, 4'hF, 1'b0};
        vec[17] = '{16'hFFFF, 1'b1, 4'h2, 4'hF, 1'b0};
        vec[18] = '{16'hFFFF, 1'b1, 4'h0, 4'h0, 1'b0};
        vec[19] = '{16'hFFFF, 1'b0, 4'h4, 4'hF, 1'b0};
        vec[20] = '{16'hFFFF, 1'b0, 4'h0, 4'h0, 1'b0};
        vec[21] = '{16'h00A5, 1'b1, 4'h0, 4'h0, 1'b0};
        vec[22] = '{16'h00A5, 1'b1, 4'h0, 4'h0, 1'b1};
        vec[23] = '{16'h00A5, 1'b1, 4'h1, 4'h5, 1'b0};
        vec[24] = '{16'h00A5, 1'b1, 4'h1, 4'h5, 1'b0};
        vec[25] = '{16'h00A5, 1'b1, 4'h0, 4'h0, 1'b0};
        vec[26] = '{16'h00A5, 1'b1, 4'h2, 4'hA, 1'b0};
        vec[27] = '{16'h00A5, 1'b1, 4'h2, 4'hA, 1'b0};

        en_def   = 1'b1;
        grid_def = '0;
        reset    = 1'b0;
        enable   = 1'b1;
        grid     = 16'h8421;
        #2;
        reset = 1'b1;
        #1;
        check("reset row_drive", 32'(row_drive), 32'h0);
        check("reset col_drive", 32'(col_drive), 32'h0);
        check("reset frame_done", 32'(frame_done), 32'h0);

        // Scan from reset, mid-frame grid change, enable drop and re-enable.
        @(negedge clock);
        reset = 1'b0;
        run_vectors(27);

        // Asynchronous reset while row 2 is lit.
        #2;
        reset = 1'b1;
        #1;
        check("async rst row_drive", 32'(row_drive), 32'h0);
        check("async rst col_drive", 32'(col_drive), 32'h0);
        check("async rst frame_done", 32'(frame_done), 32'h0);
        grid   = 16'h8421;
        enable = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        run_vectors(12);

        // Ten frames of random grids: scan invariants and snapshot contents.
        restart(16'($urandom));
        for (int r = 0; r < 4; r++) lit[r] = 0;
        last_fd  = -1;
        mdl_snap = '0;
        for (int k = 0; k <= 120; k++) begin
            tick();
            pop = $countones(row_drive);
            check("row_drive onehot", 32'(pop <= 1), 32'h1);
            if (frame_done) begin
                if (last_fd >= 0) begin
                    check("frame_done spacing", 32'(k - last_fd), 32'd12);
                    for (int r = 0; r < 4; r++) begin
                        check($sformatf("row %0d dwell", r), 32'(lit[r]), 32'd2);
                        lit[r] = 0;
                    end
                end
                last_fd  = k;
                mdl_snap = grid;
            end
            if (row_drive != 4'h0) begin
                idx = 0;
                for (int r = 0; r < 4; r++) if (row_drive[r]) idx = r;
                lit[idx]++;
                check("random col_drive", 32'(col_drive), 32'(mdl_snap[idx]));
            end
            grid = 16'($urandom);
        end
        check("frame_done seen at end", 32'(last_fd), 32'd120);

        // Default geometry: frame period 16 x (64 + 1024).
        restart(16'h0);
        seen = 1'b0;
        for (int k = 0; k < 5 && !seen; k++) begin
            tick();
            if (fd_def) seen = 1'b1;
        end
        check("default first frame_done", 32'(seen), 32'h1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!fd_def && n < 20000);
        check("default frame period", 32'(n), 32'd17408);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_scan_driver.md
# led_scan_driver

Output end of the game-of-life datapath: takes the live cell grid from the update logic and time-multiplexes it onto the row/column lines of the LED matrix board, one row at a time. Holds a frame snapshot so mid-frame grid updates never tear, and inserts blanking between rows to suppress ghosting. Drives the board pins directly through registered outputs.

## Interface
- ROWS, 16, number of matrix rows
- COLS, 16, number of matrix columns
- BLANK_CYCLES, 64, all-off cycles at the start of each row slot (≥1)
- DWELL_CYCLES, 1024, lit cycles per row slot (≥1)
- clock  input  1  system clock; all state on its rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- enable  input  1  scan enable; low forces blank and restarts the frame
- grid  input  ROWS×COLS (packed [ROWS-1:0][COLS-1:0])  live cell map, bit [r][c] = cell lit
- row_drive  output  ROWS  one-hot row select, active-high
- col_drive  output  COLS  column data for the selected row, active-high
- frame_done  output  1  one-cycle pulse at each frame start

## Operation
- State: row index `row` (0..ROWS-1), slot counter `cnt` (0..BLANK_CYCLES+DWELL_CYCLES-1), snapshot register `snap` (ROWS×COLS).
- Phases: BLANK while cnt < BLANK_CYCLES, DRIVE otherwise.
- Each cycle with enable=1: cnt increments. When cnt reaches its last value it wraps to 0 and row increments. When row is ROWS-1 it wraps to 0.
- `snap` loads `grid` on the edge that enters row 0 with cnt=0, covering reset release, enable rise and normal frame wrap. Otherwise `snap` holds.
- In BLANK: row_drive=0, col_drive=0.
- In DRIVE: row_drive = 1<<row, col_drive = snap[row].
- frame_done=1 for exactly the one cycle at row=0, cnt=0.
- enable=0: the next edge sets row=0, cnt=0 and outputs 0. frame_done stays 0 while enable=0. The first enabled cycle behaves as a frame start: snapshot is taken and frame_done pulses.
- Counter widths are $clog2 of the range, with a minimum of 1 bit. No arithmetic overflow is possible.

## Timing
- Reset values: row=0, cnt=0, snap=0, row_drive=0, col_drive=0, frame_done=0. Reset asserted mid-frame blanks the outputs asynchronously.
- After reset deassertion with enable=1:
  - The first rising edge enters the frame start state. frame_done=1 for that cycle and snap=grid from that edge.
  - Row 0 is lit from the edge after BLANK_CYCLES cycles, for exactly DWELL_CYCLES cycles.
- Row slot = BLANK_CYCLES+DWELL_CYCLES cycles. Frame = ROWS×slot cycles. frame_done period = frame.
- All outputs are registered with no combinational path from grid or enable. A grid change is visible no earlier than the next frame_done.
- Never more than one row_drive bit is high. row_drive and col_drive are both 0 on every row transition.

## Structure
- Shared package gol_pkg holds the ROWS/COLS defaults and the typedef grid_t (packed [ROWS-1:0][COLS-1:0]), used by the update logic and this block.
- Single module, no sub-module. Counter, snapshot and output registers sit in one always_ff with async reset. Phase decode is in always_comb.

## Test plan
Bench parameters: ROWS=4, COLS=4, BLANK_CYCLES=1, DWELL_CYCLES=2 (slot 3, frame 12).
- Reset, grid=16'h8421, enable=1:
  - Required cycles after release: frame_done at cycle 0; row_drive=0001, col_drive=0001 at cycles 1–2; row_drive=0010, col_drive=0010 at cycles 4–5; then rows 2 and 3.
  - Blank at cycles 0, 3, 6, 9. frame_done again at cycle 12.
- Change grid to 16'hFFFF at cycle 5 → cols stay per 16'h8421 until cycle 12. From cycle 13, col_drive=1111.
- Deassert enable at row 2 → next cycle all outputs 0 with no frame_done. Re-assert → frame_done on the first enabled cycle, then row 0 lit after 1 blank cycle.
- Assert reset asynchronously mid-DRIVE → row_drive, col_drive and frame_done go 0 before the next clock edge. Release → restart exactly as in scenario 1.
- Over 10 frames with random grid, check:
  - popcount(row_drive) ≤ 1 every cycle.
  - Each row is lit exactly DWELL_CYCLES per frame.
  - frame_done spacing is 12.
- Defaults (16×16, 64/1024) → frame_done period = 17408 cycles.
